mips32_fetch_queue: RTL and testbench

- Instruction fetch front-end that sits directly upstream of the pipelined MIPS32 IF/ID register.
- Issues word-addressed reads to instruction memory with a variable-latency req/ack handshake and buffers returned words with their next-PC in a small FIFO.
- Delivers {IR, NPC} pairs to decode over a valid/ready handshake.
- Handles branch redirects (flush and refetch) and stops fetching once an HLT opcode has been queued.

---
 rtl/mips32_fetch_queue.sv | 183 ++++++++++++++++++
 tb/tb_mips32_fetch_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// =============================================================================
// mips32_fetch_queue : MIPS32 instruction fetch front-end with {IR,NPC} queue.
// Optional macro FETCH_BYPASS_EN : zero-latency bypass of acked data when empty.
// Revision : 1.0
// =============================================================================
module mips32_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_ir,
   output logic [31:0]              out_npc,
   output logic                     fetch_halted,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int             PW      = $clog2(DEPTH);
   localparam int             CW      = PW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   localparam logic [PW-1:0]  PTR_ONE = PW'(1);
   localparam logic [5:0]     OP_HLT  = 6'b111111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      HALTSTOP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [31:0]       fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              drop, drop_nxt;
   logic              halted, halted_nxt;
   logic              ack_take;
   logic              enq_word;
   logic              deq_fifo;
   logic              fifo_valid;

   logic [31:0]       ir_mem  [DEPTH];
   logic [31:0]       npc_mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;

   // ---------------------------------------------------------------- fetch FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         addr_q   <= RESET_PC[ADDR_W-1:0];
         drop     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         addr_q   <= addr_nxt;
         drop     <= drop_nxt;
         halted   <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      addr_nxt     = addr_q;
      drop_nxt     = drop;
      halted_nxt   = halted;
      ack_take     = 1'b0;
      if (redirect_valid) begin
         fetch_pc_nxt = redirect_pc;
         halted_nxt   = 1'b0;
         if (state == REQ && !imem_ack) begin
            // Request still in flight: keep the handshake, discard its data later.
            drop_nxt = 1'b1;
         end else begin
            // Nothing outstanding after this edge, so go straight to the target.
            drop_nxt  = 1'b0;
            state_nxt = REQ;
            addr_nxt  = redirect_pc[ADDR_W-1:0];
         end
      end else begin
         case (state)
            IDLE: begin
               if (!halted && count < DEPTH_C) begin
                  state_nxt = REQ;
                  addr_nxt  = fetch_pc[ADDR_W-1:0];
               end
            end
            REQ: begin
               if (imem_ack) begin
                  if (drop) begin
                     drop_nxt  = 1'b0;
                     state_nxt = IDLE;
                  end else begin
                     ack_take     = 1'b1;
                     fetch_pc_nxt = fetch_pc + 32'd1;
                     if (imem_rdata[31:26] == OP_HLT) begin
                        state_nxt  = HALTSTOP;
                        halted_nxt = 1'b1;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end
               end
            end
            HALTSTOP: begin
               state_nxt = HALTSTOP;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   assign imem_req     = (state == REQ);
   assign imem_addr    = addr_q;
   assign fetch_halted = halted;

   // ------------------------------------------------------------ output path
   assign fifo_valid = (count != '0);
   assign deq_fifo   = fifo_valid && out_ready;

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass    = ack_take && (count == '0);
   assign out_valid = fifo_valid || bypass;
   assign out_ir    = bypass ? imem_rdata : ir_mem[rd_ptr];
   assign out_npc   = bypass ? (fetch_pc + 32'd1) : npc_mem[rd_ptr];
   assign enq_word  = ack_take && !(bypass && out_ready);
`else
   assign out_valid = fifo_valid;
   assign out_ir    = ir_mem[rd_ptr];
   assign out_npc   = npc_mem[rd_ptr];
   assign enq_word  = ack_take;
`endif

   // ---------------------------------------------------------- circular FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ir_mem[i]  <= '0;
            npc_mem[i] <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_word) begin
            ir_mem[wr_ptr]  <= imem_rdata;
            npc_mem[wr_ptr] <= fetch_pc + 32'd1;
            wr_ptr          <= wr_ptr + PTR_ONE;
         end
         if (deq_fifo) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({enq_word, deq_fifo})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign occupancy = count;

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// =============================================================================
// tb_mips32_fetch_queue : directed self-checking bench for mips32_fetch_queue.
// Revision : 1.0
// =============================================================================
module tb_mips32_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack = 1'b0;
   logic [31:0]       imem_rdata = 32'd0;
   logic              redirect_valid = 1'b0;
   logic [31:0]       redirect_pc = 32'd0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_ir;
   logic [31:0]       out_npc;
   logic              fetch_halted;
   logic [2:0]        occupancy;

   logic [31:0]       mem [1024];
   int                lat = 0;
   int                ack_count = 0;
   int                fill_base = 0;
   int                pass_cnt = 0;
   int                total_cnt = 0;

   always #5 clk = ~clk;

   mips32_fetch_queue #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .RESET_PC (32'd0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_ir         (out_ir),
      .out_npc        (out_npc),
      .fetch_halted   (fetch_halted),
      .occupancy      (occupancy)
   );

   // Instruction memory: acks after 'lat' extra cycles of a visible request.
   initial begin : responder
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (imem_req && !rst) begin
            if (wait_cnt >= lat) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr];
               ack_count++;
               wait_cnt   = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b1; lat = 3;
      repeat (2) tick();
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0h want 0", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h000) $display("FAIL reset_addr: got %0h want 0", imem_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_ir !== 32'd0) $display("FAIL reset_ir: got %0h want 0", out_ir); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'd0) $display("FAIL reset_npc: got %0h want 0", out_npc); else pass_cnt++;
      total_cnt++; if (fetch_halted !== 1'b0) $display("FAIL reset_halted: got %0h want 0", fetch_halted); else pass_cnt++;
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else pass_cnt++;
      rst = 1'b0;
      for (int i = 0; i < 10 && !imem_req; i++) tick();
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL reset_first_req: got %0h want 1", imem_req); else pass_cnt++;
      #1 rst = 1'b1;
      #1;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_async_abandon: got %0h want 0", imem_req); else pass_cnt++;
      lat = 0;
      repeat (2) tick();
   endtask

   task automatic test_program();
      logic [31:0] g_ir  [4];
      logic [31:0] g_npc [4];
      int got;
      int base;
      logic idle_req;
      got = 0;
      rst = 1'b0;
      for (int i = 0; i < 80 && got < 4; i++) begin
         tick();
         if (out_valid && out_ready) begin
            g_ir[got]  = out_ir;
            g_npc[got] = out_npc;
            got++;
         end
      end
      tick();
      total_cnt++; if (got !== 4) $display("FAIL prog_count: got %0d want 4", got); else pass_cnt++;
      for (int k = 0; k < 4 && k < got; k++) begin
         total_cnt++; if (g_ir[k] !== mem[k]) $display("FAIL prog_ir%0d: got %08h want %08h", k, g_ir[k], mem[k]); else pass_cnt++;
         total_cnt++; if (g_npc[k] !== 32'(k + 1)) $display("FAIL prog_npc%0d: got %0h want %0h", k, g_npc[k], k + 1); else pass_cnt++;
      end
      total_cnt++; if (fetch_halted !== 1'b1) $display("FAIL prog_halted: got %0h want 1", fetch_halted); else pass_cnt++;
      base = ack_count;
      idle_req = 1'b0;
      repeat (10) begin
         tick();
         if (imem_req !== 1'b0) idle_req = 1'b1;
      end
      total_cnt++; if (idle_req !== 1'b0 || ack_count != base) $display("FAIL prog_no_req_after_hlt: req_seen %0h acks %0d want 0", idle_req, ack_count - base); else pass_cnt++;
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL prog_occ: got %0d want 0", occupancy); else pass_cnt++;
   endtask

   task automatic test_halt_redirect();
      out_ready = 1'b0;
      fill_base = ack_count;
      redirect_pc = 32'h10; redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      total_cnt++; if (fetch_halted !== 1'b0) $display("FAIL halt_clear: got %0h want 0", fetch_halted); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL halt_resume_req: got %0h want 1", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h010) $display("FAIL halt_resume_addr: got %0h want 10", imem_addr); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int base;
      repeat (20) tick();
      total_cnt++; if (occupancy !== 3'd4) $display("FAIL bp_full_occ: got %0d want 4", occupancy); else pass_cnt++;
      total_cnt++; if (ack_count - fill_base != 4) $display("FAIL bp_req_count: got %0d want 4", ack_count - fill_base); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL bp_req_low: got %0h want 0", imem_req); else pass_cnt++;
      total_cnt++; if (out_ir !== mem[16'h10]) $display("FAIL bp_head_ir: got %08h want %08h", out_ir, mem[16'h10]); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'h11) $display("FAIL bp_head_npc: got %0h want 11", out_npc); else pass_cnt++;
      base = ack_count;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total_cnt++; if (occupancy !== 3'd3) $display("FAIL bp_occ_after_deq: got %0d want 3", occupancy); else pass_cnt++;
      total_cnt++; if (out_ir !== mem[16'h11]) $display("FAIL bp_next_head: got %08h want %08h", out_ir, mem[16'h11]); else pass_cnt++;
      tick();
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL bp_refill_req: got %0h want 1", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h014) $display("FAIL bp_refill_addr: got %0h want 14", imem_addr); else pass_cnt++;
      repeat (6) tick();
      total_cnt++; if (occupancy !== 3'd4) $display("FAIL bp_refill_occ: got %0d want 4", occupancy); else pass_cnt++;
      total_cnt++; if (ack_count - base != 1) $display("FAIL bp_one_req: got %0d want 1", ack_count - base); else pass_cnt++;
   endtask

   task automatic test_redirect_drop();
      logic saw_low;
      logic [ADDR_W-1:0] first_addr;
      lat = 3; out_ready = 1'b1;
      redirect_pc = 32'h5; redirect_valid = 1'b1;
      tick();
      total_cnt++; if (imem_addr !== 10'h005 || imem_req !== 1'b1) $display("FAIL drop_setup: req %0h addr %0h want 1/5", imem_req, imem_addr); else pass_cnt++;
      redirect_pc = 32'h20;
      tick();
      redirect_valid = 1'b0;
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL drop_hold_req: got %0h want 1", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h005) $display("FAIL drop_hold_addr: got %0h want 5", imem_addr); else pass_cnt++;
      saw_low = 1'b0;
      first_addr = 10'h3FF;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         tick();
         if (!imem_req) saw_low = 1'b1;
         else if (saw_low && first_addr == 10'h3FF) first_addr = imem_addr;
      end
      total_cnt++; if (first_addr !== 10'h020) $display("FAIL drop_refetch_addr: got %0h want 20", first_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL drop_timeout: got %0h want 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'h21) $display("FAIL drop_first_npc: got %0h want 21", out_npc); else pass_cnt++;
      total_cnt++; if (out_ir !== mem[16'h20]) $display("FAIL drop_first_ir: got %08h want %08h", out_ir, mem[16'h20]); else pass_cnt++;
   endtask

   task automatic test_redirect_ack_collision();
      logic found;
      logic exp_valid;
      lat = 0; out_ready = 1'b0;
      redirect_pc = 32'h30; redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (occupancy == 3'd2 && imem_ack) found = 1'b1;
      end
      total_cnt++; if (found !== 1'b1) $display("FAIL coll_setup: got %0h want 1", found); else pass_cnt++;
      redirect_pc = 32'h40; redirect_valid = 1'b1; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_BYPASS_EN
      exp_valid = 1'b1;
`else
      exp_valid = 1'b0;
`endif
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL coll_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (out_valid !== exp_valid) $display("FAIL coll_valid: got %0h want %0h", out_valid, exp_valid); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL coll_req: got %0h want 1", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h040) $display("FAIL coll_addr: got %0h want 40", imem_addr); else pass_cnt++;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      total_cnt++; if (out_ir !== mem[16'h40]) $display("FAIL coll_first_ir: got %08h want %08h", out_ir, mem[16'h40]); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'h41) $display("FAIL coll_first_npc: got %0h want 41", out_npc); else pass_cnt++;
   endtask

   task automatic test_wrap();
      out_ready = 1'b1; lat = 0;
      redirect_pc = 32'h3FF; redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL wrap_req: got %0h want 1", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h3FF) $display("FAIL wrap_addr_top: got %0h want 3ff", imem_addr); else pass_cnt++;
`ifdef FETCH_BYPASS_EN
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bypass_valid: got %0h want 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_ir !== mem[1023]) $display("FAIL bypass_ir: got %08h want %08h", out_ir, mem[1023]); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'd1024) $display("FAIL bypass_npc: got %0h want 400", out_npc); else pass_cnt++;
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL bypass_occ: got %0d want 0", occupancy); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL bypass_consumed: valid %0h occ %0d want 0/0", out_valid, occupancy); else pass_cnt++;
`else
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL wrap_no_early_valid: got %0h want 0", out_valid); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL wrap_valid: got %0h want 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_ir !== mem[1023]) $display("FAIL wrap_ir: got %08h want %08h", out_ir, mem[1023]); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'd1024) $display("FAIL wrap_npc: got %0h want 400", out_npc); else pass_cnt++;
      total_cnt++; if (occupancy !== 3'd1) $display("FAIL wrap_occ: got %0d want 1", occupancy); else pass_cnt++;
`endif
      tick();
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL wrap_next_req: got %0h want 1", imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 10'h000) $display("FAIL wrap_addr_zero: got %0h want 0", imem_addr); else pass_cnt++;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);
      mem[0] = 32'h0022_1800;
      mem[1] = 32'h2801_0005;
      mem[2] = 32'h2802_0007;
      mem[3] = 32'hFC00_0000;
      test_reset();
      test_program();
      test_halt_redirect();
      test_backpressure();
      test_redirect_drop();
      test_redirect_ack_collision();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
